// File: rtl/imu_pkg.sv
// Shared IMU definitions: sample width, calibration state encoding and the
// 17-to-16 bit saturating narrow used by every corrected axis.
package imu_pkg;

    localparam int IMU_W = 16;

    typedef enum logic [0:0] {
        CAL = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam logic signed [IMU_W-1:0] SAT_MAX = 16'sh7fff;
    localparam logic signed [IMU_W-1:0] SAT_MIN = 16'sh8000;

    // Overflow exists exactly when the two top bits of the 17-bit value differ.
    function automatic logic signed [IMU_W-1:0] sat16(input logic signed [IMU_W:0] v);
        logic signed [IMU_W-1:0] r;
        if (v[IMU_W] != v[IMU_W-1]) begin
            r = v[IMU_W] ? SAT_MIN : SAT_MAX;
        end else begin
            r = v[IMU_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bias_axis.sv
// One calibrated axis: sums 2^CAL_SAMPLES_LOG2 samples, latches their floored
// mean as the bias, and emits saturated (sample - bias) on request.
module bias_axis
    import imu_pkg::*;
#(
    parameter int CAL_SAMPLES_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    acc_en,
    input  logic                    latch,
    input  logic                    clear,
    input  logic                    run_en,
    input  logic signed [IMU_W-1:0] sample,
    output logic signed [IMU_W-1:0] bias,
    output logic signed [IMU_W-1:0] corr
);

    localparam int ACC_W = IMU_W + CAL_SAMPLES_LOG2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [IMU_W:0]   diff;

    // Running sum including the current sample, and the 17-bit correction.
    always_comb begin
        sum  = acc + {{CAL_SAMPLES_LOG2{sample[IMU_W-1]}}, sample};
        diff = {sample[IMU_W-1], sample} - {bias[IMU_W-1], bias};
    end

    // Accumulator, bias latch and corrected-output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            bias <= '0;
            corr <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (latch) begin
                // Dropping the low bits is the arithmetic shift: floor of the mean.
                bias <= sum[ACC_W-1:CAL_SAMPLES_LOG2];
                acc  <= '0;
            end else if (acc_en) begin
                acc <= sum;
            end
            if (run_en) begin
                corr <= sat16(diff);
            end
        end
    end

endmodule

// File: rtl/imu_bias_cal.sv
// Gyro zero-rate bias calibration and correction stage after the SPI driver.
// Optional macro ACCEL_CAL_EN also calibrates accel_x/accel_y (accel_z never).
module imu_bias_cal
    import imu_pkg::*;
#(
    parameter int CAL_SAMPLES_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IMU_W-1:0] in_accel_x,
    input  logic signed [IMU_W-1:0] in_accel_y,
    input  logic signed [IMU_W-1:0] in_accel_z,
    input  logic signed [IMU_W-1:0] in_gyro_x,
    input  logic signed [IMU_W-1:0] in_gyro_y,
    input  logic signed [IMU_W-1:0] in_gyro_z,
    input  logic                    recal,
    output logic                    out_valid,
    output logic signed [IMU_W-1:0] out_accel_x,
    output logic signed [IMU_W-1:0] out_accel_y,
    output logic signed [IMU_W-1:0] out_accel_z,
    output logic signed [IMU_W-1:0] out_gyro_x,
    output logic signed [IMU_W-1:0] out_gyro_y,
    output logic signed [IMU_W-1:0] out_gyro_z,
    output logic                    cal_done,
    output logic signed [IMU_W-1:0] bias_gx,
    output logic signed [IMU_W-1:0] bias_gy,
    output logic signed [IMU_W-1:0] bias_gz
`ifdef ACCEL_CAL_EN
    ,
    output logic signed [IMU_W-1:0] bias_ax,
    output logic signed [IMU_W-1:0] bias_ay
`endif
);

    localparam int CNT_W = CAL_SAMPLES_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             take;
    logic             last;
    logic             acc_en;
    logic             latch;
    logic             run_en;

    // A recal in the same cycle swallows the sample entirely.
    always_comb begin
        take = in_valid & ~recal;
        last = (cnt == CNT_LAST);
        if (state == CAL) begin
            acc_en = take & ~last;
            latch  = take & last;
            run_en = 1'b0;
        end else begin
            acc_en = 1'b0;
            latch  = 1'b0;
            run_en = take;
        end
    end

    // Calibration state machine, sample counter and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CAL;
            cnt       <= '0;
            cal_done  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= run_en;
            if (recal) begin
                state    <= CAL;
                cnt      <= '0;
                cal_done <= 1'b0;
            end else if (in_valid && state == CAL) begin
                if (last) begin
                    state    <= RUN;
                    cnt      <= '0;
                    cal_done <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    bias_axis #(.CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)) u_gx (
        .clk(clk), .rst(rst), .acc_en(acc_en), .latch(latch), .clear(recal),
        .run_en(run_en), .sample(in_gyro_x), .bias(bias_gx), .corr(out_gyro_x)
    );
    bias_axis #(.CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)) u_gy (
        .clk(clk), .rst(rst), .acc_en(acc_en), .latch(latch), .clear(recal),
        .run_en(run_en), .sample(in_gyro_y), .bias(bias_gy), .corr(out_gyro_y)
    );
    bias_axis #(.CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)) u_gz (
        .clk(clk), .rst(rst), .acc_en(acc_en), .latch(latch), .clear(recal),
        .run_en(run_en), .sample(in_gyro_z), .bias(bias_gz), .corr(out_gyro_z)
    );

`ifdef ACCEL_CAL_EN
    bias_axis #(.CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)) u_ax (
        .clk(clk), .rst(rst), .acc_en(acc_en), .latch(latch), .clear(recal),
        .run_en(run_en), .sample(in_accel_x), .bias(bias_ax), .corr(out_accel_x)
    );
    bias_axis #(.CAL_SAMPLES_LOG2(CAL_SAMPLES_LOG2)) u_ay (
        .clk(clk), .rst(rst), .acc_en(acc_en), .latch(latch), .clear(recal),
        .run_en(run_en), .sample(in_accel_y), .bias(bias_ay), .corr(out_accel_y)
    );

    // accel_z carries gravity, so it is only re-timed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_accel_z <= '0;
        end else if (run_en) begin
            out_accel_z <= in_accel_z;
        end
    end
`else
    // Accel pass-through with the same one-cycle latency as the gyro path.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_accel_x <= '0;
            out_accel_y <= '0;
            out_accel_z <= '0;
        end else if (run_en) begin
            out_accel_x <= in_accel_x;
            out_accel_y <= in_accel_y;
            out_accel_z <= in_accel_z;
        end
    end
`endif

endmodule
